// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the MIPS fetch stage:
//                sequencer states, halt sentinel, instruction field positions
//                and the branch-offset helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Sequencer states of the fetch stage
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Sentinel word that stops execution when fetched
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    // Instruction field bit positions (MIPS R/I formats)
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    // Byte offset of a branch: sign-extended word immediate times four
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem
//  Description : DEPTH x 32 instruction store with one synchronous write port
//                and one combinational read port. The read address is the
//                full word index of the PC so that out-of-range fetches can
//                return zero instead of aliasing onto valid entries.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [29:0]       raddr,
    output logic [31:0]       rdata
);

    localparam logic [29:0] c_depth = 30'(DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic        w_in_range;

    // Storage write; deliberately not reset so a reset keeps the program
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign w_in_range = (raddr < c_depth);

    // Combinational read, zero for any index beyond the array
    always_comb begin
        rdata = 32'h0;
        if (w_in_range) begin
            rdata = r_mem[raddr[ADDR_W-1:0]];
        end
    end

endmodule : instr_mem
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage of the single-cycle MIPS datapath. Holds the PC,
//                a loadable instruction memory and the LOAD/RUN/HALT
//                sequencer; presents the current instruction and its fields
//                with zero latency to main control and the datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                   ld_data,
    input  logic                          start,
    input  logic                          branch,
    input  logic                          zero,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic [31:0]                   instr,
    output logic [5:0]                    op,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [5:0]                    funct,
    output logic [15:0]                   imm,
    output logic                          running,
    output logic                          halted
);

    // Low bits forced to zero so the PC stays word aligned whatever is passed
    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};
    localparam logic [29:0] c_depth    = 30'(IMEM_DEPTH);

    fetch_state_t r_state;
    logic [31:0]  r_pc;

    logic [31:0]  w_word;
    logic         w_mem_we;
    logic         w_out_of_range;
    logic         w_halt_cond;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_branch_target;
    logic [31:0]  w_next_pc;
    logic [31:0]  w_instr;

    // Memory writes are only accepted while the sequencer is loading
    assign w_mem_we = ld_en && (r_state == LOAD);

    instr_mem #(
        .DEPTH (IMEM_DEPTH)
    ) u_instr_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (r_pc[31:2]),
        .rdata (w_word)
    );

    // A halt is taken on the sentinel word or on a fetch past the array end
    assign w_out_of_range = (r_pc[31:2] >= c_depth);
    assign w_halt_cond    = w_out_of_range || (w_word == HALT_INSTR);

    // Next-PC datapath; the immediate comes straight from the fetched word
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + branch_offset(w_word[IMM_MSB:IMM_LSB]);
    assign w_next_pc       = (branch && zero) ? w_branch_target : w_pc_plus4;

    // Sequencer and PC register; reset returns to LOAD at any time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_pc    <= c_reset_pc;
        end else begin
            case (r_state)
                LOAD: begin
                    r_pc <= c_reset_pc;
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_halt_cond) begin
                        r_state <= HALT;
                    end else begin
                        r_pc <= w_next_pc;
                    end
                end
                HALT: begin
                    if (start) begin
                        r_pc    <= c_reset_pc;
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_pc    <= c_reset_pc;
                end
            endcase
        end
    end

    // Instruction is visible only while running a non-halting fetch
    always_comb begin
        w_instr = 32'h0;
        if ((r_state == RUN) && !w_halt_cond) begin
            w_instr = w_word;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign instr    = w_instr;
    assign op       = w_instr[OP_MSB:OP_LSB];
    assign rs       = w_instr[RS_MSB:RS_LSB];
    assign rt       = w_instr[RT_MSB:RT_LSB];
    assign rd       = w_instr[RD_MSB:RD_LSB];
    assign funct    = w_instr[FUNCT_MSB:FUNCT_LSB];
    assign imm      = w_instr[IMM_MSB:IMM_LSB];
    assign running  = (r_state == RUN);
    assign halted   = (r_state == HALT);

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. Directed program runs
//                followed by randomized execution, compared every cycle
//                against a behavioural model of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int c_depth = 64;
    localparam int c_aw    = 6;
    localparam int M_LOAD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld_en;
    logic [c_aw-1:0] ld_addr;
    logic [31:0]     ld_data;
    logic            start;
    logic            branch;
    logic            zero;
    logic [31:0]     pc;
    logic [31:0]     pc_plus4;
    logic [31:0]     instr;
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [5:0]      funct;
    logic [15:0]     imm;
    logic            running;
    logic            halted;

    int passed = 0;
    int total  = 0;

    // Behavioural model: memory image, PC and mode
    logic [31:0] m_mem [c_depth];
    logic [31:0] m_pc;
    int          m_mode;

    instr_fetch #(
        .IMEM_DEPTH (c_depth),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .branch   (branch),
        .zero     (zero),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .funct    (funct),
        .imm      (imm),
        .running  (running),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Compare every output against what the model says this cycle shows
    task automatic check_outputs();
        logic [31:0] idx;
        logic [31:0] word;
        logic [31:0] ei;
        bit          stop;
        idx  = m_pc >> 2;
        word = (idx < c_depth) ? m_mem[idx[5:0]] : 32'h0;
        stop = (idx >= c_depth) || (word == HALT_INSTR);
        ei   = (m_mode == M_RUN && !stop) ? word : 32'h0;
        chk("pc",       pc,              m_pc);
        chk("pc_plus4", pc_plus4,        m_pc + 32'd4);
        chk("instr",    instr,           ei);
        chk("op",       32'(op),         ei >> 26);
        chk("rs",       32'(rs),         (ei >> 21) & 32'h1F);
        chk("rt",       32'(rt),         (ei >> 16) & 32'h1F);
        chk("rd",       32'(rd),         (ei >> 11) & 32'h1F);
        chk("funct",    32'(funct),      ei & 32'h3F);
        chk("imm",      32'(imm),        ei & 32'hFFFF);
        chk("running",  32'(running),    32'(m_mode == M_RUN));
        chk("halted",   32'(halted),     32'(m_mode == M_HALT));
    endtask

    // Advance the model by one clock edge using the inputs now applied
    task automatic model_edge();
        logic [31:0] idx;
        logic [31:0] word;
        int          off;
        idx  = m_pc >> 2;
        word = (idx < c_depth) ? m_mem[idx[5:0]] : 32'h0;
        if (m_mode == M_LOAD) begin
            if (ld_en) m_mem[ld_addr] = ld_data;
            m_pc = 32'h0;
            if (start) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (idx >= c_depth || word == HALT_INSTR) begin
                m_mode = M_HALT;
            end else begin
                off  = (branch && zero) ? 4 * int'($signed(word[15:0])) : 0;
                m_pc = m_pc + 32'd4 + 32'(off);
            end
        end else begin
            if (start) begin
                m_pc   = 32'h0;
                m_mode = M_RUN;
            end
        end
    endtask

    task automatic cycle();
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [31:0] data, input bit st);
        ld_en   = 1'b1;
        ld_addr = c_aw'(addr);
        ld_data = data;
        start   = st;
        cycle();
        ld_en   = 1'b0;
        start   = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must react at once
    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        #1;
        m_mode = M_LOAD;
        m_pc   = 32'h0;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; branch = 1'b0; zero = 1'b0;
        m_mode = M_LOAD;
        m_pc   = 32'h0;
        for (int i = 0; i < c_depth; i++) m_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();

        // lw followed by the halt sentinel; last write shares the start pulse
        for (int i = 0; i < c_depth; i++) begin
            w = (i == 0) ? 32'h8C01_0004 : ((i == 1) ? HALT_INSTR : 32'h0);
            load(i, w, i == c_depth - 1);
        end
        chk("t2_running", 32'(running), 32'd1);
        chk("t2_pc0",     pc,           32'd0);
        chk("t2_op",      32'(op),      32'h23);
        chk("t2_rs",      32'(rs),      32'd0);
        chk("t2_rt",      32'(rt),      32'd1);
        chk("t2_imm",     32'(imm),     32'd4);
        cycle();
        chk("t2_pc4",     pc,           32'd4);
        chk("t2_nop",     instr,        32'h0);
        cycle();
        chk("t2_halted",  32'(halted),  32'd1);
        chk("t2_pc_hold", pc,           32'd4);
        cycle();
        chk("t2_pc_hold2", pc,          32'd4);

        // Writes attempted while running must not reach memory
        start = 1'b1; cycle(); start = 1'b0;
        ld_en = 1'b1; ld_addr = '0; ld_data = 32'h0;
        cycle();
        ld_en = 1'b0;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        chk("t6_mem_kept", instr, 32'h8C01_0004);

        // Reset mid-run, then restart from LOAD with memory intact
        pulse_reset();
        chk("t1_pc",      pc,           32'd0);
        chk("t1_instr",   instr,        32'h0);
        start = 1'b1; cycle(); start = 1'b0;
        chk("t1_restart", instr,        32'h8C01_0004);

        // Forward/backward branches
        pulse_reset();
        for (int i = 0; i < c_depth; i++) begin
            w = (i == 2) ? 32'h1000_0003 : ((i == 3) ? 32'h1000_FFFD :
                ((i == 6) ? HALT_INSTR : 32'h0));
            load(i, w, i == c_depth - 1);
        end
        cycle();
        cycle();
        chk("t3_at8", pc, 32'd8);
        branch = 1'b1; zero = 1'b0; cycle();
        chk("t3_not_taken", pc, 32'd12);
        branch = 1'b1; zero = 1'b1; cycle();
        chk("t4_backward", pc, 32'd4);
        branch = 1'b0; zero = 1'b0; cycle();
        branch = 1'b1; zero = 1'b1; cycle();
        chk("t3_taken", pc, 32'd24);
        branch = 1'b0; zero = 1'b0; cycle();
        chk("t3_halted", 32'(halted), 32'd1);

        // Straight-line code running off the end of memory
        pulse_reset();
        for (int i = 0; i < c_depth; i++) load(i, 32'h2000_0000 | 32'(i), i == c_depth - 1);
        repeat (c_depth) cycle();
        chk("t5_pc256",  pc,           32'd256);
        chk("t5_instr0", instr,        32'h0);
        cycle();
        chk("t5_halted", 32'(halted),  32'd1);
        chk("t5_pc_hold", pc,          32'd256);
        start = 1'b1; cycle(); start = 1'b0;
        chk("t5_restart_pc",  pc,          32'd0);
        chk("t5_restart_run", 32'(running), 32'd1);

        // Randomized program and control inputs
        pulse_reset();
        for (int i = 0; i < c_depth; i++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                r = int'($urandom_range(0, 16));
                r = r - 8;
                w[15:0] = 16'(r);
            end
            if ($urandom_range(0, 15) == 0) w = HALT_INSTR;
            load(i, w, i == c_depth - 1);
        end
        for (int n = 0; n < 600; n++) begin
            branch  = 1'($urandom_range(0, 1));
            zero    = 1'($urandom_range(0, 1));
            start   = (m_mode == M_HALT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_addr = c_aw'($urandom_range(0, c_depth - 1));
            ld_data = $urandom;
            cycle();
        end
        start = 1'b0; ld_en = 1'b0; branch = 1'b0; zero = 1'b0;
        check_outputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_instr_fetch
`default_nettype wire
